// File: rtl/traffic_sensor_conditioner_if.sv
// Sensor conditioner bus: raw detector pin and controller handshake.
// master = controller side, slave = conditioner.
interface traffic_sensor_conditioner_if #(
  parameter int CNT_W = 8
);
  logic             sensor_raw;
  logic             req_ack;
  logic             sensor_clean;
  logic             car_arrive;
  logic             req;
  logic [CNT_W-1:0] car_count;

  modport master (
    output sensor_raw,
    output req_ack,
    input  sensor_clean,
    input  car_arrive,
    input  req,
    input  car_count
  );

  modport slave (
    input  sensor_raw,
    input  req_ack,
    output sensor_clean,
    output car_arrive,
    output req,
    output car_count
  );
endinterface

// File: rtl/traffic_sensor_conditioner.sv
// Vehicle detector conditioner: sync, debounce, arrival pulse,
// latched service request and saturating arrival count.
module traffic_sensor_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 8
) (
  input  logic clk,
  input  logic reset,
  traffic_sensor_conditioner_if.slave sen_if
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] REQ  = 1'b1;

  logic             s1_q, s2_q;
  logic             clean_q, clean_d;
  logic [CW-1:0]    dcnt_q, dcnt_d;
  logic             arrive_q, arrive_d;
  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             rise;
  logic             ack_acc;

  // Debounce: a disagreeing sample run of full length flips the level
  always_comb begin
    clean_d = clean_q;
    dcnt_d  = dcnt_q;
    rise    = 1'b0;
    if (s2_q == clean_q) begin
      dcnt_d = '0;
    end else if (dcnt_q == LAST) begin
      clean_d = s2_q;
      dcnt_d  = '0;
      rise    = s2_q;
    end else begin
      dcnt_d = dcnt_q + 1'b1;
    end
  end

  assign ack_acc  = (state_q == REQ) && sen_if.req_ack;
  assign arrive_d = rise;

  // Request FSM: arrival raises req, ack only lowers it without arrival
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (rise) state_d = REQ;
      REQ:  if (ack_acc && !rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Arrival count: ack restarts it, arrival on ack edge counts as one
  always_comb begin
    count_d = count_q;
    priority case (1'b1)
      ack_acc:
        count_d = rise ? CNT_W'(1) : '0;
      rise && (count_q != CMAX):
        count_d = count_q + 1'b1;
      default:
        count_d = count_q;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      clean_q  <= 1'b0;
      dcnt_q   <= '0;
      arrive_q <= 1'b0;
      state_q  <= IDLE;
      count_q  <= '0;
    end else begin
      s1_q     <= sen_if.sensor_raw;
      s2_q     <= s1_q;
      clean_q  <= clean_d;
      dcnt_q   <= dcnt_d;
      arrive_q <= arrive_d;
      state_q  <= state_d;
      count_q  <= count_d;
    end
  end

  assign sen_if.sensor_clean = clean_q;
  assign sen_if.car_arrive   = arrive_q;
  assign sen_if.req          = (state_q == REQ);
  assign sen_if.car_count    = count_q;

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// Bench for traffic_sensor_conditioner, D=4, CNT_W=2.
// Per-cycle vector table with scoreboard queue of expected outputs.
module tb_traffic_sensor_conditioner;

  localparam int D  = 4;
  localparam int CW = 2;

  logic clk = 1'b0;
  logic reset;

  traffic_sensor_conditioner_if #(.CNT_W(CW)) bus ();

  traffic_sensor_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sen_if(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic          raw;
    logic          ack;
    logic [CW+2:0] exp;
    string         tag;
  } vec_t;

  vec_t          vecs[$];
  logic [CW+2:0] sb[$];
  int            checks = 0;
  int            errors = 0;

  task automatic add(input logic rst, input logic raw, input logic ack,
                     input int n, input logic c, input logic a,
                     input logic r, input logic [CW-1:0] k,
                     input string tag);
    vec_t v;
    v.rst = rst;
    v.raw = raw;
    v.ack = ack;
    v.exp = {c, a, r, k};
    v.tag = tag;
    repeat (n) vecs.push_back(v);
  endtask

  // Full arrival then full departure of one settled vehicle
  task automatic arrival(input logic rb, input logic [CW-1:0] kb,
                         input logic [CW-1:0] ka, input string tag);
    add(0, 1, 0, D+1, 0, 0, rb, kb, {tag, "_wait"});
    add(0, 1, 0, 1,   1, 1, 1,  ka, {tag, "_arr"});
    add(0, 0, 0, D+1, 1, 0, 1,  ka, {tag, "_hold"});
    add(0, 0, 0, 1,   0, 0, 1,  ka, {tag, "_fall"});
  endtask

  task automatic check(input string tag, input logic [CW+2:0] act,
                       input logic [CW+2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b want %b", tag, act, exp);
    end
  endtask

  logic [CW-1:0] k, kn;
  logic [CW+2:0] got;
  int            edges;

  initial begin
    // reset held with raw high, then release
    add(1, 1, 0, 3,   0, 0, 0, 0, "t1_rst");
    add(0, 1, 0, D+1, 0, 0, 0, 0, "t1_lat");
    add(0, 1, 0, 1,   1, 1, 1, 1, "t1_arr");
    add(0, 1, 0, 2,   1, 0, 1, 1, "t1_hold");
    add(0, 0, 0, D+1, 1, 0, 1, 1, "t1_fwait");
    add(0, 0, 0, 1,   0, 0, 1, 1, "t1_fall");
    add(0, 0, 1, 1,   0, 0, 0, 0, "t1_ack");
    add(0, 0, 0, 1,   0, 0, 0, 0, "t1_idle");
    // glitch of D-1 samples rejected, D samples accepted
    add(0, 1, 0, D-1, 0, 0, 0, 0, "t2_glitch");
    add(0, 0, 0, 6,   0, 0, 0, 0, "t2_rej");
    add(0, 1, 0, D,   0, 0, 0, 0, "t2_pulse");
    add(0, 0, 0, 1,   0, 0, 0, 0, "t2_e5");
    add(0, 0, 0, 1,   1, 1, 1, 1, "t2_e6");
    add(0, 0, 0, D-1, 1, 0, 1, 1, "t2_fwait");
    add(0, 0, 0, 1,   0, 0, 1, 1, "t2_fall");
    // second arrival while req held, ack, ack in IDLE
    arrival(1, 1, 2, "t3_a2");
    add(0, 0, 1, 1,   0, 0, 0, 0, "t3_ack");
    add(0, 0, 1, 2,   0, 0, 0, 0, "t3_idle_ack");
    // arrival on same edge as accepted ack
    arrival(0, 0, 1, "t4_a1");
    add(0, 1, 0, D+1, 0, 0, 1, 1, "t4_wait");
    add(0, 1, 1, 1,   1, 1, 1, 1, "t4_simul");
    add(0, 1, 0, 1,   1, 0, 1, 1, "t4_after");
    add(0, 0, 0, D+1, 1, 0, 1, 1, "t4_fwait");
    add(0, 0, 0, 1,   0, 0, 1, 1, "t4_fall");
    // saturation
    add(0, 0, 1, 1,   0, 0, 0, 0, "t5_ack0");
    k = '0;
    for (int j = 0; j < 5; j++) begin
      kn = (k == 2'd3) ? 2'd3 : k + 2'd1;
      arrival((j != 0), k, kn, $sformatf("t5_sat%0d", j));
      k = kn;
    end
    add(0, 0, 1, 1,   0, 0, 0, 0, "t5_ack");
    // reset mid-operation: req=1, count=2, debounce mid-count
    arrival(0, 0, 1, "t6_a1");
    arrival(1, 1, 2, "t6_a2");
    add(0, 1, 0, 3,   0, 0, 1, 2, "t6_mid");
    add(1, 1, 0, 1,   0, 0, 0, 0, "t6_rst");

    foreach (vecs[i]) begin
      reset          = vecs[i].rst;
      bus.sensor_raw = vecs[i].raw;
      bus.req_ack    = vecs[i].ack;
      sb.push_back(vecs[i].exp);
      @(posedge clk);
      #1;
      got = {bus.sensor_clean, bus.car_arrive, bus.req, bus.car_count};
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_empty at %s", vecs[i].tag);
      end else begin
        check(vecs[i].tag, got, sb.pop_front());
      end
    end

    // fresh full-latency arrival after mid-operation reset
    reset          = 1'b0;
    bus.sensor_raw = 1'b1;
    bus.req_ack    = 1'b0;
    edges          = 0;
    while (edges < 20) begin
      @(posedge clk);
      #1;
      edges++;
      if (bus.car_arrive) break;
    end
    checks++;
    if (edges != D + 2) begin
      errors++;
      $display("FAIL t6_latency got %0d edges want %0d", edges, D + 2);
    end
    check("t6_fresh", {bus.sensor_clean, bus.car_arrive, bus.req,
                       bus.car_count}, {1'b1, 1'b1, 1'b1, 2'd1});
    @(posedge clk);
    #1;
    check("t6_pulse_end", {bus.sensor_clean, bus.car_arrive, bus.req,
                           bus.car_count}, {1'b1, 1'b0, 1'b1, 2'd1});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
